// File: rtl/shift_tx8.sv
// shift_tx8: parallel-in, serial-out transmitter with a per-bit shift strobe and a done pulse.
// Optional build macro SHIFT_TX8_PARITY_EN appends an even-parity bit after the data bits.
module shift_tx8 #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             stall,
  output logic             s_out,
  output logic             shift_en,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
`ifdef SHIFT_TX8_PARITY_EN
  localparam int unsigned LastIdx = WIDTH;
`else
  localparam int unsigned LastIdx = WIDTH - 1;
`endif
  localparam logic [CntW-1:0] LastCnt = CntW'(LastIdx);
  localparam logic [CntW-1:0] OneCnt  = CntW'(1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             load_ready_q, load_ready_d;
  logic             shift_en_q, shift_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] d_rev;

`ifdef SHIFT_TX8_PARITY_EN
  logic par_q, par_d;
`endif

  // LSB-first words are loaded bit-reversed so the register always shifts towards the MSB.
  always_comb begin
    d_rev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      d_rev[i] = d_in[WIDTH-1-i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
`ifdef SHIFT_TX8_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (load_valid && load_ready_q) begin
          state_d = StShift;
          cnt_d   = '0;
          sreg_d  = MSB_FIRST ? d_in : d_rev;
`ifdef SHIFT_TX8_PARITY_EN
          par_d   = ^d_in;
`endif
        end
      end
      StShift: begin
        if (!stall) begin
          if (cnt_q == LastCnt) begin
            state_d = StDone;
            cnt_d   = '0;
            sreg_d  = '0;
`ifdef SHIFT_TX8_PARITY_EN
          end else if (cnt_q == CntW'(WIDTH - 1)) begin
            cnt_d  = cnt_q + OneCnt;
            sreg_d = {par_q, {(WIDTH-1){1'b0}}};
`endif
          end else begin
            cnt_d  = cnt_q + OneCnt;
            sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so every output leaves a flop.
  always_comb begin
    load_ready_d = (state_d == StIdle);
    busy_d       = (state_d != StIdle);
    done_d       = (state_d == StDone);
    shift_en_d   = (state_d == StShift) && !((state_q == StShift) && stall);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      sreg_q       <= '0;
      load_ready_q <= 1'b1;
      shift_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sreg_q       <= sreg_d;
      load_ready_q <= load_ready_d;
      shift_en_q   <= shift_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

`ifdef SHIFT_TX8_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign load_ready = load_ready_q;
  assign s_out      = sreg_q[WIDTH-1];
  assign shift_en   = shift_en_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
